apb4_regfile_slave: RTL and testbench
=====================================

Name: apb4_regfile_slave

Overview:
- APB4 completer at the far end of the AHB-to-APB sync bridge. Responds to paddr/psel/penable/pwrite/pwdata/pstrb/pport with prdata/pready/pslverr.
- Holds a small register file: ID, CTRL and scratch registers.
- CTRL programs the wait states and error behaviour, so the bench can exercise every bridge handshake path from software.
- Runs on the bridge clock; serves as the default APB target in bridge-level simulation.

Parameters:
- ADDRWIDTH, 12, width of paddr.
- NUM_REGS, 8, number of 32-bit word registers. Index = paddr[ADDRWIDTH-1:2]. Minimum 3.
- ID_VALUE, 32'hA5B4_0001, read-only contents of register 0.
- RST_WAIT, 4'd0, reset value of CTRL.wait.

Ports:
- clk  in  1  APB clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- paddr  in  ADDRWIDTH  byte address; bits [1:0] are ignored.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  32  write data.
- pstrb  in  4  write byte strobes.
- pport  in  3  protection attributes; bit 0 = privileged.
- prdata  out  32  read data.
- pready  out  1  transfer completion.
- pslverr  out  1  transfer error.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. All outputs are registered.
- Reset values: prdata=0, pready=0, pslverr=0, FSM=IDLE, CTRL={err_en=1, wait=RST_WAIT}, scratch registers = 0.
- FSM states:
  - IDLE → SETUP when psel=1 and penable=0.
  - SETUP → ACCESS unconditionally. On this edge, latch index, pwrite, pwdata, pstrb and pport[0]; load the wait counter with CTRL.wait.
  - ACCESS: while the counter is nonzero, decrement it and hold pready=0. When the counter is 0, assert pready=1 for exactly one cycle, then go to DONE.
  - DONE → SETUP if psel=1 and penable=0 (back-to-back transfer); otherwise → IDLE.
- Latency: wait=N gives pready high in the (N+1)-th cycle after the setup cycle. N=0 gives a zero-wait transfer (setup, then access with pready=1). N ranges 0..15.
- Register map (word index):
  - 0: ID, read-only.
  - 1: CTRL. Bits [3:0] = wait, bit 4 = err_en, other bits read 0.
  - 2..NUM_REGS-1: scratch, read/write.
- Write commit: on the edge ending the pready cycle. Only bytes with pstrb[i]=1 are updated. A write with pstrb=0 completes OKAY and changes nothing.
- Read data: prdata is driven with the register contents in the pready cycle and is 0 in all other cycles. A read of an out-of-range index returns 0.
- Error conditions (checked against the latched attributes):
  - index ≥ NUM_REGS;
  - write to ID;
  - write to CTRL with pport[0]=0.
- Error response:
  - If err_en=1: pslverr=1 in the pready cycle, and the write is suppressed.
  - If err_en=0: OKAY response, and the write is still suppressed.
  - pslverr is never high while pready=0.
- Writes to CTRL take effect from the next transfer. A transfer never uses a wait value it wrote itself.
- psel dropping in SETUP or ACCESS before pready (protocol abort): return to IDLE, no write, pready and pslverr stay 0.
- penable=1 seen in IDLE without a preceding setup cycle: ignored, no response.
- Reset asserted mid-transfer: immediate return to reset values; any pending write is discarded.
- Input changes during ACCESS are ignored; only values latched in SETUP are used.

Decomposition:
- Shared package apb_regfile_pkg:
  - FSM state enum (IDLE, SETUP, ACCESS, DONE);
  - register index constants (IDX_ID=0, IDX_CTRL=1, IDX_SCR0=2);
  - CTRL field positions;
  - a byte-merge function (old, new, strb) → merged.
- One natural sub-module, apb_wait_counter: 4-bit loadable down-counter with load, en and zero outputs.
- The register array and decode stay in the top module.

Test Plan:
- Zero-wait write then read: write 0x1234_5678 to 0x008 with pstrb=4'hF, then read 0x008 → pready in the access cycle, prdata=0x1234_5678, pslverr=0.
- Wait states: privileged write of CTRL=0x13 (wait=3), then read ID → pready rises exactly 4 cycles after the setup cycle, prdata=0xA5B4_0001, pready stays 0 until then.
- Byte strobes: scratch register holds 0xFFFF_FFFF; write 0x0000_0000 with pstrb=4'b0101 → readback 0xFF00_FF00.
- Errors with err_en=1:
  - write ID → pslverr=1 with pready, ID unchanged;
  - read index 8 → pslverr=1, prdata=0;
  - CTRL write with pport=3'b000 → pslverr=1, CTRL unchanged.
- Error masking: with err_en=0, a write to 0x020 → pslverr=0 and no register changes. Back-to-back transfers with no idle cycle both complete.
- Abort and reset: drop psel during a wait=5 access → no pready, no write. Assert rst mid-access → outputs 0 immediately, CTRL reads 0x10 after reset.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the APB4 register-file completer.
// Holds the FSM state set, the register map indices and the CTRL field layout.
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } apb_state_e;

    localparam int IDX_ID   = 0;
    localparam int IDX_CTRL = 1;
    localparam int IDX_SCR0 = 2;

    localparam int CTRL_WAIT_LSB   = 0;
    localparam int CTRL_WAIT_W     = 4;
    localparam int CTRL_ERR_EN_BIT = 4;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// 4-bit loadable down-counter that times the APB wait states.
// It stops at zero; zero is the cue to complete the access.
module apb_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/apb4_regfile_slave.sv
// APB4 completer with ID, CTRL and scratch registers; CTRL sets the wait
// states and whether decode/permission errors are reported on pslverr.
module apb4_regfile_slave
    import apb_regfile_pkg::*;
#(
    parameter int          ADDRWIDTH = 12,
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] ID_VALUE  = 32'hA5B4_0001,
    parameter logic [3:0]  RST_WAIT  = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDRWIDTH-1:0] paddr,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          pwdata,
    input  logic [3:0]           pstrb,
    input  logic [2:0]           pport,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr
);

    localparam int IDX_W  = ADDRWIDTH - 2;
    localparam int SLOT_W = $clog2(NUM_REGS);

    apb_state_e state_q, state_d, phase;
    logic latch, cnt_load, cnt_en, cnt_zero, set_rdy, commit;

    logic [IDX_W-1:0] idx_q;
    logic             write_q, priv_q;
    logic [31:0]      wdata_q;
    logic [3:0]       strb_q;

    logic [3:0]  wait_q;
    logic        err_en_q;
    logic [31:0] scratch_q [NUM_REGS];

    logic [IDX_W-1:0]  eff_idx;
    logic [SLOT_W-1:0] slot;
    logic              eff_write, eff_priv, in_range, is_id, is_ctrl, err;
    logic [31:0]       ctrl_word, rd_word, merged;
    logic              unused_bits;

    assign unused_bits = ^{paddr[1:0], pport[2:1]};

    // In the setup cycle the attributes are still on the bus; afterwards use the latched copy.
    assign eff_idx   = latch ? paddr[ADDRWIDTH-1:2] : idx_q;
    assign eff_write = latch ? pwrite : write_q;
    assign eff_priv  = latch ? pport[0] : priv_q;
    assign slot      = eff_idx[SLOT_W-1:0];
    assign in_range  = 32'(eff_idx) < NUM_REGS;
    assign is_id     = 32'(eff_idx) == IDX_ID;
    assign is_ctrl   = 32'(eff_idx) == IDX_CTRL;
    assign err       = !in_range || (eff_write && is_id) || (eff_write && is_ctrl && !eff_priv);

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_WAIT_LSB +: CTRL_WAIT_W] = wait_q;
        ctrl_word[CTRL_ERR_EN_BIT]              = err_en_q;
    end

    always_comb begin
        rd_word = '0;
        if (is_id)                                  rd_word = ID_VALUE;
        else if (is_ctrl)                           rd_word = ctrl_word;
        else if (in_range && 32'(eff_idx) >= IDX_SCR0) rd_word = scratch_q[slot];
    end

    assign merged = byte_merge(is_ctrl ? ctrl_word : scratch_q[slot], wdata_q, strb_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // A setup cycle is recognised combinationally from IDLE or DONE so the
    // registered pready can already rise in the first access cycle.
    always_comb begin
        state_d  = state_q;
        phase    = state_q;
        latch    = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        set_rdy  = 1'b0;
        commit   = 1'b0;
        if ((state_q == ST_IDLE || state_q == ST_DONE) && psel && !penable) phase = ST_SETUP;
        unique case (phase)
            ST_SETUP: begin
                state_d  = ST_ACCESS;
                latch    = 1'b1;
                cnt_load = 1'b1;
                set_rdy  = (wait_q == 4'd0);
            end
            ST_ACCESS: begin
                if (pready) begin
                    commit  = 1'b1;
                    state_d = ST_DONE;
                end else if (!psel) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    set_rdy = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    apb_wait_counter u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (wait_q - 4'd1),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (latch) begin
            idx_q   <= paddr[ADDRWIDTH-1:2];
            write_q <= pwrite;
            priv_q  <= pport[0];
            wdata_q <= pwdata;
            strb_q  <= pstrb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q   <= RST_WAIT;
            err_en_q <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) scratch_q[i] <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
        end else begin
            pready  <= set_rdy;
            pslverr <= set_rdy && err && err_en_q;
            prdata  <= (set_rdy && !eff_write) ? rd_word : '0;
            // Errored writes are dropped whether or not they are reported.
            if (commit && write_q && !err) begin
                if (is_ctrl) begin
                    wait_q   <= merged[CTRL_WAIT_LSB +: CTRL_WAIT_W];
                    err_en_q <= merged[CTRL_ERR_EN_BIT];
                end else begin
                    scratch_q[slot] <= merged;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb4_regfile_slave.sv
// Bench for apb4_regfile_slave: directed vector table, hand-built abort and
// reset sequences, then randomized transfers scored against a register model.
module tb_apb4_regfile_slave;

    localparam logic [31:0] ID_VAL = 32'hA5B4_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pport = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;

    apb4_regfile_slave dut (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pport(pport),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what software would believe the register file holds.
    logic [31:0] m_regs [8];
    logic [3:0]  m_wait;
    logic        m_err_en;

    typedef struct {
        logic        w;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        bit          b2b;
        logic [31:0] exp_rd;
        logic        exp_se;
        int          exp_lat;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_wait   = 4'd0;
        m_err_en = 1'b1;
    endtask

    task automatic model_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [2:0] p,
                              output logic [31:0] exp_rd, output logic exp_se, output int exp_lat);
        int idx;
        bit bad;
        logic [31:0] word;
        idx     = int'(a[11:2]);
        bad     = (idx >= 8) || (w && idx == 0) || (w && idx == 1 && !p[0]);
        exp_lat = int'(m_wait) + 1;
        exp_se  = bad && m_err_en;
        exp_rd  = '0;
        if (!w && idx < 8) begin
            if (idx == 0)      exp_rd = ID_VAL;
            else if (idx == 1) exp_rd = {27'd0, m_err_en, m_wait};
            else               exp_rd = m_regs[idx];
        end
        if (w && !bad) begin
            word = (idx == 1) ? {27'd0, m_err_en, m_wait} : m_regs[idx];
            for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
            if (idx == 1) begin
                m_wait   = word[3:0];
                m_err_en = word[4];
            end else begin
                m_regs[idx] = word;
            end
        end
    endtask

    // Leaves psel high after the pready sample so the caller may chain a back-to-back transfer.
    task automatic apb_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p,
                            output logic [31:0] rd, output logic se, output int lat, output bit quiet);
        lat = 0; quiet = 1'b1; rd = '0; se = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s; pport = p;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr = a ^ 12'h004; pwdata = ~d; pstrb = ~s;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (pready) begin
                lat = k; rd = prdata; se = pslverr;
                break;
            end
            if (pslverr || prdata != 0) quiet = 1'b0;
        end
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic run_checked(input string tag, input logic w, input logic [11:0] a,
                               input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                               input bit b2b);
        logic [31:0] rd, erd;
        logic se, ese;
        int lat, elat;
        bit quiet;
        model_xfer(w, a, d, s, p, erd, ese, elat);
        apb_xfer(w, a, d, s, p, rd, se, lat, quiet);
        check({tag, " latency"}, lat, elat);
        check({tag, " pslverr"}, se, ese);
        check({tag, " quiet_before_ready"}, quiet, 1);
        if (!w) check({tag, " prdata"}, rd, erd);
        if (!b2b) bus_idle();
    endtask

    initial begin
        logic [31:0] rd;
        logic se;
        int lat;
        bit quiet, seen;
        logic [31:0] unused_rd;
        logic [31:0] dummy_rd;
        logic dummy_se;
        int dummy_lat;

        //        w     addr     wdata          strb   prot  b2b  exp_rd         se  lat
        vecs[0]  = '{1'b1, 12'h008, 32'h1234_5678, 4'hF, 3'd1, 1, 32'h0,         0, 1};
        vecs[1]  = '{1'b0, 12'h008, 32'h0,         4'h0, 3'd1, 0, 32'h1234_5678, 0, 1};
        vecs[2]  = '{1'b1, 12'h00C, 32'hFFFF_FFFF, 4'hF, 3'd1, 0, 32'h0,         0, 1};
        vecs[3]  = '{1'b1, 12'h00C, 32'h0000_0000, 4'h5, 3'd1, 0, 32'h0,         0, 1};
        vecs[4]  = '{1'b0, 12'h00C, 32'h0,         4'h0, 3'd1, 0, 32'hFF00_FF00, 0, 1};
        vecs[5]  = '{1'b1, 12'h000, 32'hDEAD_BEEF, 4'hF, 3'd1, 0, 32'h0,         1, 1};
        vecs[6]  = '{1'b0, 12'h000, 32'h0,         4'h0, 3'd1, 0, ID_VAL,        0, 1};
        vecs[7]  = '{1'b0, 12'h020, 32'h0,         4'h0, 3'd1, 0, 32'h0,         1, 1};
        vecs[8]  = '{1'b1, 12'h004, 32'h0000_001F, 4'hF, 3'd0, 0, 32'h0,         1, 1};
        vecs[9]  = '{1'b0, 12'h004, 32'h0,         4'h0, 3'd0, 0, 32'h0000_0010, 0, 1};
        vecs[10] = '{1'b1, 12'h004, 32'h0000_0013, 4'hF, 3'd1, 1, 32'h0,         0, 1};
        vecs[11] = '{1'b0, 12'h000, 32'h0,         4'h0, 3'd1, 0, ID_VAL,        0, 4};
        vecs[12] = '{1'b0, 12'h004, 32'h0,         4'h0, 3'd1, 0, 32'h0000_0013, 0, 4};
        vecs[13] = '{1'b1, 12'h004, 32'h0000_0002, 4'hF, 3'd1, 0, 32'h0,         0, 4};
        vecs[14] = '{1'b1, 12'h020, 32'hAAAA_5555, 4'hF, 3'd1, 1, 32'h0,         0, 3};
        vecs[15] = '{1'b1, 12'h000, 32'h1111_2222, 4'hF, 3'd1, 0, 32'h0,         0, 3};
        vecs[16] = '{1'b0, 12'h000, 32'h0,         4'h0, 3'd1, 0, ID_VAL,        0, 3};
        vecs[17] = '{1'b0, 12'h020, 32'h0,         4'h0, 3'd1, 0, 32'h0,         0, 3};
        vecs[18] = '{1'b1, 12'h004, 32'h0000_0010, 4'hF, 3'd1, 0, 32'h0,         0, 3};
        vecs[19] = '{1'b0, 12'h008, 32'h0,         4'h0, 3'd1, 0, 32'h1234_5678, 0, 1};

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pready", pready, 0);
        check("reset pslverr", pslverr, 0);
        check("reset prdata", prdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            model_xfer(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
                       dummy_rd, dummy_se, dummy_lat);
            apb_xfer(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
                     rd, se, lat, quiet);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d pslverr", i), se, vecs[i].exp_se);
            check($sformatf("vec%0d quiet_before_ready", i), quiet, 1);
            if (!vecs[i].w) check($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rd);
            if (!vecs[i].b2b) bus_idle();
        end

        // Abort: wait=5, drop psel part-way through the access.
        run_checked("set_wait5", 1'b1, 12'h004, 32'h0000_0015, 4'hF, 3'd1, 0);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h5A5A_5A5A;
        pstrb = 4'hF; pport = 3'd1;
        @(posedge clk); #1 penable = 1'b1;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); if (pready) seen = 1'b1; end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        repeat (8) begin @(negedge clk); if (pready || pslverr) seen = 1'b1; end
        check("abort no_response", seen, 0);
        run_checked("abort readback", 1'b0, 12'h010, 32'h0, 4'h0, 3'd1, 0);

        // Access phase without a setup cycle is ignored.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h000;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (pready) seen = 1'b1; end
        check("penable_no_setup ignored", seen, 0);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;

        // Reset during the pready cycle of an ID read.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
        @(posedge clk); #1 penable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (pready) seen = 1'b1;
        end
        check("pre_reset pready", seen, 1);
        check("pre_reset prdata", prdata, ID_VAL);
        #1 rst = 1'b1;
        #1;
        check("async_reset pready", pready, 0);
        check("async_reset pslverr", pslverr, 0);
        check("async_reset prdata", prdata, 0);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        run_checked("post_reset ctrl", 1'b0, 12'h004, 32'h0, 4'h0, 3'd1, 0);
        run_checked("post_reset scratch", 1'b0, 12'h008, 32'h0, 4'h0, 3'd1, 0);

        // Randomized transfers scored against the model.
        for (int i = 0; i < 80; i++) begin
            logic [11:0] a;
            a = {$urandom_range(0, 9) & 10'h3FF, 2'($urandom_range(0, 3))};
            run_checked($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                        4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                        ($urandom_range(0, 3) == 0));
        end
        bus_idle();

        unused_rd = rd;
        if (unused_rd === 32'hx) $display("note: last read undefined");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
